// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program loader: FSM encoding and block size.
// The block size matches the instruction memory and the scheduler arithmetic.
package carregador_programa_pkg;

    localparam int TAM_BLOCO_PADRAO = 200;

    typedef enum logic [2:0] {
        OCIOSO,
        LE_TAMANHO,
        VALIDA,
        LE_PALAVRA,
        ESCREVE,
        FIM,
        ERRO
    } estado_t;

    function automatic logic [31:0] base_bloco(input logic [31:0] n, input int tam);
        return n * 32'(tam);
    endfunction

endpackage

// File: rtl/carregador_programa_if.sv
// Loader bus bundle: control unit start/status, HD word port, instruction memory port.
// The loader side is the master; the control unit, HD and memory form the slave side.
interface carregador_programa_if #(
    parameter int HD_AW = 16
);

    logic              iniciar;
    logic [7:0]        num_programa;
    logic [31:0]       bloco_destino;
    logic              hd_leitura;
    logic [HD_AW-1:0]  hd_endereco;
    logic [31:0]       hd_dado;
    logic              hd_valido;
    logic              mem_escrita;
    logic [31:0]       mem_endereco;
    logic [31:0]       mem_dado;
    logic              ocupado;
    logic              concluido;
    logic              erro;

    modport master (
        input  iniciar, num_programa, bloco_destino, hd_dado, hd_valido,
        output hd_leitura, hd_endereco, mem_escrita, mem_endereco, mem_dado,
        output ocupado, concluido, erro
    );

    modport slave (
        output iniciar, num_programa, bloco_destino, hd_dado, hd_valido,
        input  hd_leitura, hd_endereco, mem_escrita, mem_endereco, mem_dado,
        input  ocupado, concluido, erro
    );

endinterface

// File: rtl/carregador_programa_leitor_hd.sv
// HD read handshake: raises the request, holds the address, drops on valid.
// Valid is only honoured while a request is outstanding.
module carregador_programa_leitor_hd #(
    parameter int HD_AW = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pedir,
    input  logic [31:0]      endereco,
    input  logic             valido,
    output logic             leitura,
    output logic [HD_AW-1:0] endereco_hd,
    output logic             pronto
);

    assign pronto = leitura && valido;

    always_ff @(posedge clock) begin
        if (!reset) begin
            leitura     <= 1'b0;
            endereco_hd <= '0;
        end else if (!leitura && pedir) begin
            leitura     <= 1'b1;
            endereco_hd <= HD_AW'(endereco);
        end else if (pronto) begin
            leitura     <= 1'b0;
        end
    end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: copies one HD program image into a process block of
// instruction memory, reporting completion or rejection to the control unit.
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int TAM_BLOCO     = TAM_BLOCO_PADRAO,
    parameter int NUM_PROCESSOS = 5,
    parameter int HD_AW         = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    carregador_programa_if.master bus
);

    localparam logic [31:0] TAM   = 32'(TAM_BLOCO);
    localparam logic [31:0] NPROC = 32'(NUM_PROCESSOS);

    estado_t     estado;
    estado_t     prox;
    logic [31:0] base_hd;
    logic [31:0] base_mem;
    logic [31:0] tamanho;
    logic [31:0] indice;
    logic [31:0] mem_end_q;
    logic [31:0] mem_dado_q;
    logic [31:0] end_leitura;
    logic        pedir;
    logic        pronto;
    logic        aceita;
    logic        ocupado_c;
    logic        concluido_c;
    logic        erro_c;
    logic        escrita_c;

    assign aceita = (estado == OCIOSO) && bus.iniciar;
    assign pedir  = (estado == LE_TAMANHO) || (estado == LE_PALAVRA);

    // Word 0 of the image holds the length; instructions follow it.
    assign end_leitura = (estado == LE_TAMANHO) ? base_hd : base_hd + indice;

    carregador_programa_leitor_hd #(
        .HD_AW(HD_AW)
    ) u_leitor_hd (
        .clock       (clock),
        .reset       (reset),
        .pedir       (pedir),
        .endereco    (end_leitura),
        .valido      (bus.hd_valido),
        .leitura     (bus.hd_leitura),
        .endereco_hd (bus.hd_endereco),
        .pronto      (pronto)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO: begin
                if (bus.iniciar) begin
                    prox = (bus.bloco_destino >= NPROC) ? ERRO : LE_TAMANHO;
                end
            end
            LE_TAMANHO: begin
                if (pronto) prox = VALIDA;
            end
            VALIDA: begin
                prox = (tamanho == 32'd0 || tamanho >= TAM) ? ERRO : LE_PALAVRA;
            end
            LE_PALAVRA: begin
                if (pronto) prox = ESCREVE;
            end
            ESCREVE: begin
                prox = (indice == tamanho) ? FIM : LE_PALAVRA;
            end
            FIM:     prox = OCIOSO;
            ERRO:    prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado_c   = (estado != OCIOSO);
        concluido_c = (estado == FIM);
        erro_c      = (estado == ERRO);
        escrita_c   = (estado == ESCREVE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            base_hd    <= '0;
            base_mem   <= '0;
            tamanho    <= '0;
            indice     <= '0;
            mem_end_q  <= '0;
            mem_dado_q <= '0;
        end else begin
            if (aceita) begin
                base_hd  <= base_bloco(32'(bus.num_programa), TAM_BLOCO);
                base_mem <= base_bloco(bus.bloco_destino, TAM_BLOCO);
            end
            if (estado == LE_TAMANHO && pronto) begin
                tamanho <= bus.hd_dado;
            end
            if (estado == VALIDA) begin
                indice <= 32'd1;
            end
            // Address/data are staged here so they are stable for the write cycle.
            if (estado == LE_PALAVRA && pronto) begin
                mem_dado_q <= bus.hd_dado;
                mem_end_q  <= base_mem + indice - 32'd1;
            end
            if (estado == ESCREVE && indice != tamanho) begin
                indice <= indice + 32'd1;
            end
        end
    end

    assign bus.ocupado      = ocupado_c;
    assign bus.concluido    = concluido_c;
    assign bus.erro         = erro_c;
    assign bus.mem_escrita  = escrita_c;
    assign bus.mem_endereco = mem_end_q;
    assign bus.mem_dado     = mem_dado_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for the program loader: HD latency model, write scoreboard,
// table of load cases plus reset, stray-valid and restart sequences.
module tb_carregador_programa;

    typedef struct {
        int          prog;
        logic [31:0] dest;
        int          k;
        int          len;
        bit          exp_err;
        int          ciclos;
    } caso_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } esc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_esc = 0;
    int          n_conc = 0;
    int          n_err = 0;
    int          n_leit = 0;
    int          k_lat = 1;
    int          lat_cnt = 0;
    logic        stray = 1'b0;
    logic [31:0] hd_mem [0:2047];
    esc_t        fila[$];
    caso_t       casos[9];

    always #5 clock = ~clock;

    carregador_programa_if #(.HD_AW(16)) bus ();

    carregador_programa dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // HD model: valid comes k edges after the request is first seen high.
    assign bus.hd_valido = (bus.hd_leitura && lat_cnt == k_lat - 1) || stray;
    assign bus.hd_dado   = hd_mem[bus.hd_endereco[10:0]];

    always @(posedge clock) begin
        if (!bus.hd_leitura || bus.hd_valido) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (bus.mem_escrita) begin
                n_esc++;
                chk("write_expected", 32'(fila.size() != 0), 32'd1);
                if (fila.size() != 0) begin
                    esc_t e;
                    e = fila.pop_front();
                    chk("mem_endereco", bus.mem_endereco, e.addr);
                    chk("mem_dado", bus.mem_dado, e.data);
                end
            end
            if (bus.concluido) n_conc++;
            if (bus.erro) n_err++;
            if (bus.hd_leitura) n_leit++;
        end
    end

    task automatic esperar_escritas(input caso_t c, input int n);
        for (int i = 1; i <= n; i++) begin
            fila.push_back('{addr: c.dest * 32'd200 + 32'(i) - 32'd1,
                             data: hd_mem[c.prog * 200 + i]});
        end
    endtask

    task automatic carrega(input caso_t c, input int intruso, input string nome);
        int ciclos;
        int conc0;
        int err0;
        int esc0;
        int leit0;
        conc0 = n_conc;
        err0  = n_err;
        esc0  = n_esc;
        leit0 = n_leit;
        k_lat = c.k;
        if (!c.exp_err) esperar_escritas(c, c.len);
        bus.num_programa  = 8'(c.prog);
        bus.bloco_destino = c.dest;
        bus.iniciar       = 1'b1;
        @(posedge clock); #1;
        bus.iniciar       = 1'b0;
        bus.num_programa  = 8'd9;
        bus.bloco_destino = 32'd3;
        chk({nome, " ocupado"}, 32'(bus.ocupado), 32'd1);
        ciclos = 0;
        while (!(bus.concluido || bus.erro) && ciclos < 3000) begin
            bus.iniciar = (ciclos == intruso);
            @(posedge clock); #1;
            ciclos++;
        end
        bus.iniciar = 1'b0;
        chk({nome, " cycles"}, 32'(ciclos), 32'(c.ciclos));
        chk({nome, " erro"}, 32'(bus.erro), 32'(c.exp_err));
        chk({nome, " concluido"}, 32'(bus.concluido), 32'(!c.exp_err));
        @(posedge clock); #1;
        chk({nome, " pulse_end"}, 32'(bus.concluido | bus.erro), 32'd0);
        chk({nome, " idle"}, 32'(bus.ocupado), 32'd0);
        @(negedge clock);
        chk({nome, " n_concluido"}, 32'(n_conc - conc0), 32'(!c.exp_err));
        chk({nome, " n_erro"}, 32'(n_err - err0), 32'(c.exp_err));
        chk({nome, " n_writes"}, 32'(n_esc - esc0), c.exp_err ? 32'd0 : 32'(c.len));
        chk({nome, " queue"}, 32'(fila.size()), 32'd0);
        if (c.ciclos == 0) chk({nome, " no_hd_read"}, 32'(n_leit - leit0), 32'd0);
    endtask

    task automatic chk_zeros(input string nome);
        chk({nome, " ocupado"}, 32'(bus.ocupado), 32'd0);
        chk({nome, " concluido"}, 32'(bus.concluido), 32'd0);
        chk({nome, " erro"}, 32'(bus.erro), 32'd0);
        chk({nome, " hd_leitura"}, 32'(bus.hd_leitura), 32'd0);
        chk({nome, " hd_endereco"}, 32'(bus.hd_endereco), 32'd0);
        chk({nome, " mem_escrita"}, 32'(bus.mem_escrita), 32'd0);
        chk({nome, " mem_endereco"}, bus.mem_endereco, 32'd0);
        chk({nome, " mem_dado"}, bus.mem_dado, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int esc0;
        int conc0;
        int err0;
        for (int a = 0; a < 2048; a++) hd_mem[a] = 32'hC000_0000 + 32'(a);
        hd_mem[2 * 200] = 32'd3;
        hd_mem[3 * 200] = 32'd1;
        hd_mem[4 * 200] = 32'd0;
        hd_mem[5 * 200] = 32'd200;
        hd_mem[6 * 200] = 32'd199;
        hd_mem[9 * 200] = 32'd2;
        hd_mem[2 * 200 + 1] = 32'h0000_000A;
        hd_mem[2 * 200 + 2] = 32'h0000_000B;
        hd_mem[2 * 200 + 3] = 32'h0000_000C;

        casos[0] = '{2, 32'd1, 2, 3, 1'b0, 16};
        casos[1] = '{2, 32'd4, 1, 3, 1'b0, 12};
        casos[2] = '{2, 32'd4, 5, 3, 1'b0, 28};
        casos[3] = '{4, 32'd2, 2, 0, 1'b1, 4};
        casos[4] = '{5, 32'd3, 2, 200, 1'b1, 4};
        casos[5] = '{2, 32'd5, 2, 3, 1'b1, 0};
        casos[6] = '{2, 32'hFFFF_FFFF, 1, 3, 1'b1, 0};
        casos[7] = '{6, 32'd0, 1, 199, 1'b0, 600};
        casos[8] = '{3, 32'd0, 3, 1, 1'b0, 10};

        bus.iniciar       = 1'b0;
        bus.num_programa  = 8'd0;
        bus.bloco_destino = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk_zeros("reset");
        @(negedge clock);
        reset = 1'b1;

        foreach (casos[i]) carrega(casos[i], -1, $sformatf("case%0d", i));

        // Start request repeated mid-load with different inputs.
        carrega(casos[0], 5, "restart_ignored");

        // Valid with no outstanding request is ignored.
        @(negedge clock);
        stray = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        @(posedge clock); #1;
        chk("stray ocupado", 32'(bus.ocupado), 32'd0);
        chk("stray hd_leitura", 32'(bus.hd_leitura), 32'd0);

        // Reset after the second write aborts without a pulse.
        esc0  = n_esc;
        conc0 = n_conc;
        err0  = n_err;
        k_lat = 2;
        esperar_escritas(casos[0], 2);
        @(negedge clock);
        bus.num_programa  = 8'd2;
        bus.bloco_destino = 32'd1;
        bus.iniciar       = 1'b1;
        @(posedge clock); #1;
        bus.iniciar = 1'b0;
        for (int i = 0; i < 100 && n_esc < esc0 + 2; i++) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk_zeros("abort");
        @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        chk("abort n_writes", 32'(n_esc - esc0), 32'd2);
        chk("abort n_concluido", 32'(n_conc - conc0), 32'd0);
        chk("abort n_erro", 32'(n_err - err0), 32'd0);
        chk("abort queue", 32'(fila.size()), 32'd0);

        carrega(casos[0], -1, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
